// File: rtl/note_player.sv
// Note player: loads note/duration from the song reader, counts beats, pulses note_done,
// and answers the activate/parameters handshake. Optional macro: NOTE_PLAYER_FAST_FWD_EN.
module note_player #(
    parameter int unsigned NOTE_W  = 6,
    parameter int unsigned DUR_W   = 6,
    parameter int unsigned PARAM_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               play,
    input  logic               load_new_note,
    input  logic [NOTE_W-1:0]  note,
    input  logic [DUR_W-1:0]   duration,
    input  logic               beat,
    input  logic               ff_switch0,
    input  logic               activate,
    input  logic [PARAM_W-1:0] parameters,
    output logic               note_done,
    output logic               note_active,
    output logic [NOTE_W-1:0]  current_note,
    output logic [DUR_W-1:0]   beats_left,
    output logic [PARAM_W-1:0] timbre,
    output logic               activate_done
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        DONE    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [NOTE_W-1:0] note_nxt;
    logic [DUR_W-1:0]  beats_nxt;
    logic [DUR_W-1:0]  dec;
    logic              done_nxt;
    logic              active_nxt;

    // Beats consumed per qualifying beat tick
`ifdef NOTE_PLAYER_FAST_FWD_EN
    assign dec = ff_switch0 ? DUR_W'(2) : DUR_W'(1);
`else
    logic unused_ff_switch0;
    assign unused_ff_switch0 = ff_switch0;
    assign dec = DUR_W'(1);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            current_note <= '0;
            beats_left   <= '0;
            note_done    <= 1'b0;
            note_active  <= 1'b0;
        end else begin
            state        <= state_nxt;
            current_note <= note_nxt;
            beats_left   <= beats_nxt;
            note_done    <= done_nxt;
            note_active  <= active_nxt;
        end
    end

    // A load wins over everything, including a coincident beat or the DONE cycle
    always_comb begin
        state_nxt = state;
        note_nxt  = current_note;
        beats_nxt = beats_left;
        if (load_new_note) begin
            note_nxt  = note;
            beats_nxt = duration;
            state_nxt = (duration == DUR_W'(0)) ? DONE : PLAYING;
        end else begin
            case (state)
                PLAYING: begin
                    if (beat && play) begin
                        if (beats_left <= dec) begin
                            beats_nxt = '0;
                            state_nxt = DONE;
                        end else begin
                            beats_nxt = beats_left - dec;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        done_nxt   = (state_nxt == DONE);
        active_nxt = (state_nxt == PLAYING) && (note_nxt != NOTE_W'(0));
    end

    // Four-phase responder: latch once per request, release after activate drops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timbre        <= '0;
            activate_done <= 1'b0;
        end else if (activate && !activate_done) begin
            timbre        <= parameters;
            activate_done <= 1'b1;
        end else if (!activate) begin
            activate_done <= 1'b0;
        end
    end

endmodule

// File: tb/tb_note_player.sv
// Directed self-checking bench for note_player; expectations follow the macro
// NOTE_PLAYER_FAST_FWD_EN when the fast-forward feature is built in.
module tb_note_player;

    logic       clk = 1'b0;
    logic       reset;
    logic       play;
    logic       load_new_note;
    logic [5:0] note;
    logic [5:0] duration;
    logic       beat;
    logic       ff_switch0;
    logic       activate;
    logic [2:0] parameters;
    logic       note_done;
    logic       note_active;
    logic [5:0] current_note;
    logic [5:0] beats_left;
    logic [2:0] timbre;
    logic       activate_done;

    int n_cmp = 0;
    int n_err = 0;

    note_player dut (
        .clk(clk), .reset(reset), .play(play), .load_new_note(load_new_note),
        .note(note), .duration(duration), .beat(beat), .ff_switch0(ff_switch0),
        .activate(activate), .parameters(parameters), .note_done(note_done),
        .note_active(note_active), .current_note(current_note), .beats_left(beats_left),
        .timbre(timbre), .activate_done(activate_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input logic [5:0] n, input logic [5:0] d);
        note = n; duration = d; load_new_note = 1'b1;
        step(1);
        load_new_note = 1'b0;
    endtask

    task automatic pulse_beat();
        step(9);
        beat = 1'b1;
        step(1);
        beat = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(2);
        n_cmp++; if ({note_done, note_active, current_note, beats_left, timbre, activate_done} !== 17'd0) begin n_err++; $display("FAIL reset_outputs: got %b want 0", {note_done, note_active, current_note, beats_left, timbre, activate_done}); end
        reset = 1'b0;
        step(1);
    endtask

    task automatic test_basic();
        load(6'd12, 6'd4);
        n_cmp++; if (current_note !== 6'd12) begin n_err++; $display("FAIL basic_note: got %0d want 12", current_note); end
        n_cmp++; if (note_active !== 1'b1) begin n_err++; $display("FAIL basic_active: got %b want 1", note_active); end
        n_cmp++; if (beats_left !== 6'd4) begin n_err++; $display("FAIL basic_left0: got %0d want 4", beats_left); end
        for (int i = 1; i <= 4; i++) begin
            pulse_beat();
            n_cmp++; if (beats_left !== 6'(4 - i)) begin n_err++; $display("FAIL basic_left%0d: got %0d want %0d", i, beats_left, 4 - i); end
            n_cmp++; if (note_done !== (i == 4)) begin n_err++; $display("FAIL basic_done%0d: got %b want %b", i, note_done, (i == 4)); end
        end
        n_cmp++; if (note_active !== 1'b0) begin n_err++; $display("FAIL basic_active_done: got %b want 0", note_active); end
        step(1);
        n_cmp++; if (note_done !== 1'b0) begin n_err++; $display("FAIL basic_single_pulse: got %b want 0", note_done); end
        n_cmp++; if (current_note !== 6'd12) begin n_err++; $display("FAIL basic_idle_hold: got %0d want 12", current_note); end
    endtask

    task automatic test_pause();
        load(6'd12, 6'd4);
        play = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pulse_beat();
            n_cmp++; if (beats_left !== 6'd4) begin n_err++; $display("FAIL pause_hold%0d: got %0d want 4", i, beats_left); end
            n_cmp++; if (note_active !== 1'b1) begin n_err++; $display("FAIL pause_active%0d: got %b want 1", i, note_active); end
        end
        play = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            pulse_beat();
            n_cmp++; if (note_done !== (i == 4)) begin n_err++; $display("FAIL pause_done%0d: got %b want %b", i, note_done, (i == 4)); end
        end
        step(1);
    endtask

    task automatic test_zero_duration();
        load(6'd7, 6'd0);
        n_cmp++; if (note_done !== 1'b1) begin n_err++; $display("FAIL zero_done: got %b want 1", note_done); end
        n_cmp++; if (note_active !== 1'b0) begin n_err++; $display("FAIL zero_active: got %b want 0", note_active); end
        step(1);
        n_cmp++; if (note_done !== 1'b0) begin n_err++; $display("FAIL zero_pulse_end: got %b want 0", note_done); end
    endtask

    task automatic test_abort();
        load(6'd20, 6'd5);
        pulse_beat();
        pulse_beat();
        n_cmp++; if (beats_left !== 6'd3) begin n_err++; $display("FAIL abort_pre: got %0d want 3", beats_left); end
        step(9);
        note = 6'd0; duration = 6'd2; load_new_note = 1'b1; beat = 1'b1;
        step(1);
        load_new_note = 1'b0; beat = 1'b0;
        n_cmp++; if (note_done !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got %b want 0", note_done); end
        n_cmp++; if (note_active !== 1'b0) begin n_err++; $display("FAIL abort_rest_active: got %b want 0", note_active); end
        n_cmp++; if (beats_left !== 6'd2) begin n_err++; $display("FAIL abort_left: got %0d want 2", beats_left); end
        pulse_beat();
        n_cmp++; if ({beats_left, note_done} !== {6'd1, 1'b0}) begin n_err++; $display("FAIL abort_beat1: got %0d/%b want 1/0", beats_left, note_done); end
        pulse_beat();
        n_cmp++; if ({beats_left, note_done} !== {6'd0, 1'b1}) begin n_err++; $display("FAIL abort_beat2: got %0d/%b want 0/1", beats_left, note_done); end
        step(1);
    endtask

    task automatic test_load_in_done();
        load(6'd3, 6'd1);
        pulse_beat();
        n_cmp++; if (note_done !== 1'b1) begin n_err++; $display("FAIL done_load_pulse: got %b want 1", note_done); end
        load(6'd9, 6'd2);
        n_cmp++; if ({note_active, beats_left, note_done} !== {1'b1, 6'd2, 1'b0}) begin n_err++; $display("FAIL done_load_accept: got %b/%0d/%b want 1/2/0", note_active, beats_left, note_done); end
        pulse_beat();
        pulse_beat();
        step(1);
    endtask

    task automatic test_activate();
        parameters = 3'd5; activate = 1'b1;
        step(1);
        n_cmp++; if ({timbre, activate_done} !== {3'd5, 1'b1}) begin n_err++; $display("FAIL act_latch: got %0d/%b want 5/1", timbre, activate_done); end
        parameters = 3'd2;
        step(2);
        n_cmp++; if ({timbre, activate_done} !== {3'd5, 1'b1}) begin n_err++; $display("FAIL act_hold: got %0d/%b want 5/1", timbre, activate_done); end
        activate = 1'b0;
        step(1);
        n_cmp++; if ({timbre, activate_done} !== {3'd5, 1'b0}) begin n_err++; $display("FAIL act_release: got %0d/%b want 5/0", timbre, activate_done); end
        parameters = 3'd3; activate = 1'b1;
        step(1);
        n_cmp++; if ({timbre, activate_done} !== {3'd3, 1'b1}) begin n_err++; $display("FAIL act_second: got %0d/%b want 3/1", timbre, activate_done); end
        activate = 1'b0;
        step(1);
    endtask

    task automatic test_fast_fwd();
        ff_switch0 = 1'b1;
        load(6'd15, 6'd3);
`ifdef NOTE_PLAYER_FAST_FWD_EN
        pulse_beat();
        n_cmp++; if ({beats_left, note_done} !== {6'd1, 1'b0}) begin n_err++; $display("FAIL ff_beat1: got %0d/%b want 1/0", beats_left, note_done); end
        pulse_beat();
        n_cmp++; if ({beats_left, note_done} !== {6'd0, 1'b1}) begin n_err++; $display("FAIL ff_beat2: got %0d/%b want 0/1", beats_left, note_done); end
`else
        for (int i = 1; i <= 3; i++) begin
            pulse_beat();
            n_cmp++; if ({beats_left, note_done} !== {6'(3 - i), (i == 3)}) begin n_err++; $display("FAIL ff_off_beat%0d: got %0d/%b want %0d/%b", i, beats_left, note_done, 3 - i, (i == 3)); end
        end
`endif
        ff_switch0 = 1'b0;
        step(1);
    endtask

    task automatic test_reset_mid_note();
        activate = 1'b1; parameters = 3'd6;
        load(6'd10, 6'd5);
        pulse_beat();
        activate = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++; if ({note_done, note_active, current_note, beats_left, timbre, activate_done} !== 17'd0) begin n_err++; $display("FAIL reset_async: got %b want 0", {note_done, note_active, current_note, beats_left, timbre, activate_done}); end
        step(2);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            pulse_beat();
            n_cmp++; if ({note_done, note_active, beats_left} !== 8'd0) begin n_err++; $display("FAIL reset_no_done%0d: got %b want 0", i, {note_done, note_active, beats_left}); end
        end
    endtask

    initial begin
        reset = 1'b1; play = 1'b1; load_new_note = 1'b0; note = '0; duration = '0;
        beat = 1'b0; ff_switch0 = 1'b0; activate = 1'b0; parameters = '0;
        test_reset();
        test_basic();
        test_pause();
        test_zero_duration();
        test_abort();
        test_load_in_done();
        test_activate();
        test_fast_fwd();
        test_reset_mid_note();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
